// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: MEM/WB pipe vs. a one-entry long-latency result buffer.
// Optional starvation guard (FORCE state, age counter) enabled by macro WBARB_AGE_EN.
module wb_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   output logic        pipe_stall,
   input  logic        lu_valid,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);

   localparam int unsigned RW = 5;
   localparam int unsigned DW = 32;

   if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
      $error("wb_port_arbiter: STARVE_MAX must be in 1..7");
   end

`ifdef WBARB_AGE_EN
   localparam int unsigned CW = 3;
   typedef enum logic [1:0] {EMPTY, HELD, FORCE} state_t;
`else
   typedef enum logic [1:0] {EMPTY, HELD} state_t;
`endif

   state_t        state, state_nxt;
   logic [RW-1:0] ent_rd, ent_rd_nxt;
   logic [DW-1:0] ent_data, ent_data_nxt;
   logic          we_nxt;
   logic [RW-1:0] waddr_nxt;
   logic [DW-1:0] wdata_nxt;
   logic          pipe_req;
   logic          lu_take;

`ifdef WBARB_AGE_EN
   logic [CW-1:0] age, age_nxt, age_inc;
   assign age_inc    = (age == CW'(7)) ? age : age + CW'(1);
   assign pipe_stall = (state == FORCE);
`else
   assign pipe_stall = 1'b0;
`endif

   assign lu_ready = (state == EMPTY);
   assign pipe_req = pipe_valid && (pipe_rd != '0);
   assign lu_take  = lu_valid && lu_ready && (lu_rd != '0);

   // State, entry and registered register-file write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         ent_rd   <= '0;
         ent_data <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
`ifdef WBARB_AGE_EN
         age      <= '0;
`endif
      end else begin
         state    <= state_nxt;
         ent_rd   <= ent_rd_nxt;
         ent_data <= ent_data_nxt;
         rf_we    <= we_nxt;
         rf_waddr <= waddr_nxt;
         rf_wdata <= wdata_nxt;
`ifdef WBARB_AGE_EN
         age      <= age_nxt;
`endif
      end
   end

   // Next-state and write selection
   always_comb begin
      state_nxt    = state;
      ent_rd_nxt   = ent_rd;
      ent_data_nxt = ent_data;
      we_nxt       = 1'b0;
      waddr_nxt    = rf_waddr;
      wdata_nxt    = rf_wdata;
`ifdef WBARB_AGE_EN
      age_nxt      = age;
`endif
      case (state)
         EMPTY: begin
            if (pipe_req) begin
               we_nxt    = 1'b1;
               waddr_nxt = pipe_rd;
               wdata_nxt = pipe_data;
            end
            if (lu_take) begin
               state_nxt    = HELD;
               ent_rd_nxt   = lu_rd;
               ent_data_nxt = lu_data;
`ifdef WBARB_AGE_EN
               age_nxt      = '0;
`endif
            end
         end
         HELD: begin
            we_nxt = 1'b1;
            if (pipe_req) begin
               waddr_nxt = pipe_rd;
               wdata_nxt = pipe_data;
               // Same destination: the younger pipe write supersedes the entry
               if (pipe_rd == ent_rd) begin
                  state_nxt = EMPTY;
               end else begin
`ifdef WBARB_AGE_EN
                  age_nxt = age_inc;
                  if (age_inc >= CW'(STARVE_MAX)) state_nxt = FORCE;
`endif
               end
            end else begin
               waddr_nxt = ent_rd;
               wdata_nxt = ent_data;
               state_nxt = EMPTY;
            end
         end
`ifdef WBARB_AGE_EN
         FORCE: begin
            we_nxt    = 1'b1;
            waddr_nxt = ent_rd;
            wdata_nxt = ent_data;
            state_nxt = EMPTY;
         end
`endif
         default: state_nxt = EMPTY;
      endcase
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus starvation and reset sequences.
module tb_wb_port_arbiter;

`ifdef WBARB_AGE_EN
   localparam bit AGE_EN = 1'b1;
`else
   localparam bit AGE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        pipe_stall;
   logic        lu_valid;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   wb_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .pipe_stall(pipe_stall),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [4:0]  prd;
      logic [31:0] pdata;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        rdy;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                               input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic rdy);
      vec_t v;
      v.pv = pv; v.prd = prd; v.pdata = pdata;
      v.lv = lv; v.lrd = lrd; v.ldata = ldata;
      v.we = we; v.waddr = waddr; v.wdata = wdata; v.rdy = rdy;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
      pipe_valid = pv; pipe_rd = prd; pipe_data = pdata;
      lu_valid = lv; lu_rd = lrd; lu_data = ldata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      bit stall_cyc;
      // idle / lu capture+drain / pipe+lu together / pipe wins / free slot / squash / rd0 discard
      vecs[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 32'h0,        1);
      vecs[1]  = mk(0, 0, 0,            1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        0);
      vecs[2]  = mk(0, 0, 0,            0, 0, 0,            1, 5, 32'hDEADBEEF, 1);
      vecs[3]  = mk(0, 0, 0,            0, 0, 0,            0, 5, 32'hDEADBEEF, 1);
      vecs[4]  = mk(1, 3, 32'h33,       1, 7, 32'h77,       1, 3, 32'h33,       0);
      vecs[5]  = mk(1, 3, 32'h11,       0, 0, 0,            1, 3, 32'h11,       0);
      vecs[6]  = mk(1, 8, 32'h88,       0, 0, 0,            1, 8, 32'h88,       0);
      vecs[7]  = mk(1, 0, 32'h99,       0, 0, 0,            1, 7, 32'h77,       1);
      vecs[8]  = mk(0, 0, 0,            1, 9, 32'h99999999, 0, 7, 32'h77,       0);
      vecs[9]  = mk(1, 9, 32'h22,       0, 0, 0,            1, 9, 32'h22,       1);
      vecs[10] = mk(0, 0, 0,            0, 0, 0,            0, 9, 32'h22,       1);
      vecs[11] = mk(0, 0, 0,            1, 0, 32'h55,       0, 9, 32'h22,       1);
      vecs[12] = mk(1, 6, 32'h60,       1, 6, 32'h66,       1, 6, 32'h60,       0);
      vecs[13] = mk(0, 0, 0,            0, 0, 0,            1, 6, 32'h66,       1);
      vecs[14] = mk(0, 0, 0,            0, 0, 0,            0, 6, 32'h66,       1);

      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      tick();
      tick();
      check("reset rf_we",      32'(rf_we),      32'd0);
      check("reset rf_waddr",   32'(rf_waddr),   32'd0);
      check("reset rf_wdata",   rf_wdata,        32'd0);
      check("reset lu_ready",   32'(lu_ready),   32'd1);
      check("reset pipe_stall", 32'(pipe_stall), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].pv, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
         tick();
         check($sformatf("vec%0d rf_we", i),      32'(rf_we),      32'(vecs[i].we));
         check($sformatf("vec%0d rf_waddr", i),   32'(rf_waddr),   32'(vecs[i].waddr));
         check($sformatf("vec%0d rf_wdata", i),   rf_wdata,        vecs[i].wdata);
         check($sformatf("vec%0d lu_ready", i),   32'(lu_ready),   32'(vecs[i].rdy));
         check($sformatf("vec%0d pipe_stall", i), 32'(pipe_stall), 32'd0);
      end

      // Starvation: entry rd=4 under continuous pipe traffic
      drive(0, 0, 0, 1, 4, 32'h44);
      tick();
      check("starve capture lu_ready", 32'(lu_ready), 32'd0);
      k = 0;
      for (int c = 0; c < 7; c++) begin
         stall_cyc = AGE_EN && (c == 4);
         drive(1, 5'(10 + k), 32'h100 + 32'(k), 0, 0, 0);
         tick();
         check($sformatf("starve c%0d rf_we", c),    32'(rf_we),    32'd1);
         check($sformatf("starve c%0d rf_waddr", c), 32'(rf_waddr), stall_cyc ? 32'd4 : 32'(10 + k));
         check($sformatf("starve c%0d rf_wdata", c), rf_wdata,      stall_cyc ? 32'h44 : 32'h100 + 32'(k));
         check($sformatf("starve c%0d pipe_stall", c), 32'(pipe_stall), 32'(AGE_EN && (c == 3)));
         check($sformatf("starve c%0d lu_ready", c), 32'(lu_ready), 32'(AGE_EN && (c >= 4)));
         if (!stall_cyc) k++;
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      check("starve drain rf_we",    32'(rf_we),    AGE_EN ? 32'd0 : 32'd1);
      check("starve drain rf_waddr", 32'(rf_waddr), AGE_EN ? 32'd15 : 32'd4);
      check("starve drain rf_wdata", rf_wdata,      AGE_EN ? 32'h105 : 32'h44);
      check("starve drain lu_ready", 32'(lu_ready), 32'd1);

      // Mid-operation reset discards the buffered rd=6 entry
      drive(0, 0, 0, 1, 6, 32'h600D);
      tick();
      check("rst held lu_ready", 32'(lu_ready), 32'd0);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("rst async lu_ready", 32'(lu_ready), 32'd1);
      check("rst async rf_we",    32'(rf_we),    32'd0);
      check("rst async rf_waddr", 32'(rf_waddr), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("post-rst c%0d rf_we", c),    32'(rf_we),    32'd0);
         check($sformatf("post-rst c%0d rf_waddr", c), 32'(rf_waddr), 32'd0);
         check($sformatf("post-rst c%0d lu_ready", c), 32'(lu_ready), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
